// File: rtl/fib_result_uart_tx_if.sv
// Calculator-result / UART pin bundle between the Fibonacci calculator side and the
// hex-dump transmitter.
interface fib_result_uart_tx_if #(
  parameter int WIDTH = 69
);
  logic             load;
  logic [WIDTH-1:0] data;
  logic             tx;
  logic             tx_en;
  logic             busy;
  logic             done;

  modport master (output load, data, input tx, tx_en, busy, done);
  modport slave  (input load, data, output tx, tx_en, busy, done);
endinterface

// File: rtl/fib_result_uart_tx.sv
// Captures the calculator result on the rising edge of load and sends it as uppercase
// hex (MSB first, optional CR LF) in 8N1 UART frames.
module fib_result_uart_tx #(
  parameter int WIDTH        = 69,
  parameter int CLKS_PER_BIT = 434,
  parameter int APPEND_CRLF  = 1
) (
  input logic                 clk,
  input logic                 rst,
  fib_result_uart_tx_if.slave bus
);
  localparam int NDIG  = (WIDTH + 3) / 4;
  localparam int NCHAR = NDIG + 2 * APPEND_CRLF;
  localparam int SW    = NDIG * 4;
  localparam int CW    = $clog2(CLKS_PER_BIT);
  localparam int IW    = $clog2(NCHAR + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]    state;
  logic          load_q;
  logic [SW-1:0] sh, ext;
  logic [7:0]    chr, nxt_chr;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [IW-1:0] idx, idx_n;
  logic          tx_r, done_r, bit_end, last_chr;

  function automatic logic [7:0] hex(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  always_comb begin
    ext            = '0;
    ext[WIDTH-1:0] = bus.data;
    idx_n          = idx + IW'(1);
    bit_end        = (cnt == CW'(CLKS_PER_BIT - 1));
    last_chr       = (idx == IW'(NCHAR - 1));
    // Digits come off the top of the shift register; the tail is CR then LF.
    if (idx_n < IW'(NDIG))       nxt_chr = hex(sh[SW-1 -: 4]);
    else if (idx_n == IW'(NDIG)) nxt_chr = 8'h0D;
    else                         nxt_chr = 8'h0A;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      load_q  <= 1'b0;
      sh      <= '0;
      chr     <= '0;
      cnt     <= '0;
      bit_idx <= '0;
      idx     <= '0;
      tx_r    <= 1'b1;
      done_r  <= 1'b0;
    end else begin
      load_q <= bus.load;
      done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.load && !load_q) begin
            // First digit is latched now, so sh holds the remaining digits.
            state <= S_START;
            sh    <= ext << 4;
            chr   <= hex(ext[SW-1 -: 4]);
            idx   <= '0;
            cnt   <= '0;
            tx_r  <= 1'b0;
          end
        end
        S_START: begin
          if (bit_end) begin
            cnt     <= '0;
            bit_idx <= '0;
            tx_r    <= chr[0];
            state   <= S_DATA;
          end else cnt <= cnt + CW'(1);
        end
        S_DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx_r  <= 1'b1;
              state <= S_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx_r    <= chr[bit_idx + 3'd1];
            end
          end else cnt <= cnt + CW'(1);
        end
        S_STOP: begin
          if (bit_end) begin
            cnt <= '0;
            if (last_chr) begin
              state  <= S_IDLE;
              done_r <= 1'b1;
            end else begin
              state <= S_START;
              tx_r  <= 1'b0;
              idx   <= idx_n;
              chr   <= nxt_chr;
              if (idx_n < IW'(NDIG)) sh <= sh << 4;
            end
          end else cnt <= cnt + CW'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.tx    = tx_r;
  assign bus.tx_en = 1'b1;
  assign bus.busy  = (state != S_IDLE);
  assign bus.done  = done_r;
endmodule

// File: tb/tb_fib_result_uart_tx.sv
// Randomized bench: a UART receiver decodes both DUTs' tx lines and messages are
// compared with a hex-string model built from the captured value.
module tb_fib_result_uart_tx;
  localparam int C = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fib_result_uart_tx_if #(.WIDTH(69)) b1 ();
  fib_result_uart_tx_if #(.WIDTH(69)) b2 ();

  fib_result_uart_tx #(.WIDTH(69), .CLKS_PER_BIT(C), .APPEND_CRLF(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
  fib_result_uart_tx #(.WIDTH(69), .CLKS_PER_BIT(C), .APPEND_CRLF(0)) u2 (.clk(clk), .rst(rst), .bus(b2));

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];

  logic [1:0] txw, busyw, donew;
  assign txw   = {b2.tx, b1.tx};
  assign busyw = {b2.busy, b1.busy};
  assign donew = {b2.done, b1.done};

  // Receiver state per DUT (0 = CRLF build, 1 = digits-only build).
  logic [7:0] rx_buf[2][1024];
  int         rx_n[2];
  int         rx_cnt[2];
  int         frame_err[2];
  bit         rx_act[2];
  logic [7:0] rx_b[2];

  initial begin
    for (int p = 0; p < 2; p++) begin
      rx_n[p] = 0; rx_cnt[p] = 0; frame_err[p] = 0; rx_act[p] = 1'b0; rx_b[p] = '0;
    end
  end

  always @(negedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (rst) rx_act[p] <= 1'b0;
      else if (!rx_act[p]) begin
        if (txw[p] == 1'b0) begin
          rx_act[p] <= 1'b1;
          rx_cnt[p] <= 1;
        end
      end else begin
        if (rx_cnt[p] == C/2 && txw[p] != 1'b0) frame_err[p] <= frame_err[p] + 1;
        for (int k = 1; k <= 8; k++)
          if (rx_cnt[p] == k*C + C/2) rx_b[p][k-1] <= txw[p];
        if (rx_cnt[p] == 9*C + C/2 && txw[p] != 1'b1) frame_err[p] <= frame_err[p] + 1;
        if (rx_cnt[p] == 10*C - 1) begin
          if (rx_n[p] < 1024) rx_buf[p][rx_n[p]] <= rx_b[p];
          rx_n[p]   <= rx_n[p] + 1;
          rx_act[p] <= 1'b0;
        end else rx_cnt[p] <= rx_cnt[p] + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected message: 18 hex digits of the zero-extended value, MSB first, then CR LF.
  function automatic void model(input logic [71:0] v, input bit crlf);
    int nib;
    exp_q.delete();
    for (int i = 17; i >= 0; i--) begin
      nib = int'((v >> (4*i)) & 72'hF);
      exp_q.push_back(nib < 10 ? 8'(48 + nib) : 8'(55 + nib));
    end
    if (crlf) begin
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endfunction

  function automatic logic [68:0] rnd();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[68:0];
  endfunction

  task automatic set_load(input int p, input logic l);
    if (p == 0) b1.load = l; else b2.load = l;
  endtask

  task automatic set_data(input int p, input logic [68:0] d);
    if (p == 0) b1.data = d; else b2.data = d;
  endtask

  // mode 0: plain; 1: second rising edge mid-message; 2: load held high 2000 cycles.
  // pre: load/data already driven by a chained predecessor; chain: re-arm on done.
  task automatic run_msg(input int p, input logic [68:0] d, input int mode, input string tag,
                         input bit pre, input bit chain, input logic [68:0] nd);
    int exp_cyc, done_at, busy_cnt, base, fe0, tail, xdone, xbusy;
    exp_cyc = (p == 0 ? 20 : 18) * 10 * C;
    done_at = -1; busy_cnt = 0; xdone = 0; xbusy = 0;
    model({3'b0, d}, p == 0);
    base = rx_n[p];
    fe0  = frame_err[p];
    if (!pre) begin
      @(negedge clk);
      set_data(p, d);
      set_load(p, 1'b1);
    end
    @(posedge clk);
    for (int i = 0; i < exp_cyc + 40; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk($sformatf("%s_start_tx", tag), txw[p], 1'b0);
        chk($sformatf("%s_start_busy", tag), busyw[p], 1'b1);
      end
      if (i == 10 && mode != 2) set_load(p, 1'b0);
      if (i == 50) set_data(p, ~d);
      if (mode == 1 && i == 300) set_load(p, 1'b1);
      if (busyw[p]) busy_cnt++;
      if (donew[p]) begin done_at = i; break; end
    end
    if (chain && done_at >= 0) begin
      set_data(p, nd);
      set_load(p, 1'b1);
    end
    chk($sformatf("%s_done_cyc", tag), done_at, exp_cyc);
    chk($sformatf("%s_busy_cyc", tag), busy_cnt, exp_cyc);
    if (mode != 0) begin
      tail = (mode == 2) ? 2000 - exp_cyc : 200;
      for (int j = 0; j < tail; j++) begin
        @(negedge clk);
        if (donew[p]) xdone++;
        if (busyw[p]) xbusy++;
      end
      chk($sformatf("%s_extra_done", tag), xdone, 0);
      chk($sformatf("%s_extra_busy", tag), xbusy, 0);
      set_load(p, 1'b0);
    end
    chk($sformatf("%s_len", tag), rx_n[p] - base, exp_q.size());
    for (int k = 0; k < exp_q.size(); k++)
      if (base + k < rx_n[p] && base + k < 1024)
        chk($sformatf("%s_b%0d", tag, k), rx_buf[p][base+k], exp_q[k]);
    chk($sformatf("%s_frame", tag), frame_err[p] - fe0, 0);
  endtask

  initial begin
    int bad_tx, bad_busy, bad_done, base, nb;
    logic [68:0] ra, rb, f100;
    string s;
    rst = 1'b1;
    b1.load = 1'b0; b1.data = '0;
    b2.load = 1'b0; b2.data = '0;
    repeat (3) @(negedge clk);
    chk("rst_tx", b1.tx, 1'b1);
    chk("rst_busy", b1.busy, 1'b0);
    chk("rst_done", b1.done, 1'b0);
    chk("rst_tx_en", b1.tx_en, 1'b1);
    chk("rst_tx2", b2.tx, 1'b1);
    chk("rst_tx_en2", b2.tx_en, 1'b1);
    rst = 1'b0;

    bad_tx = 0; bad_busy = 0; bad_done = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (txw != 2'b11) bad_tx++;
      if (busyw != 2'b00) bad_busy++;
      if (donew != 2'b00) bad_done++;
    end
    chk("idle_tx", bad_tx, 0);
    chk("idle_busy", bad_busy, 0);
    chk("idle_done", bad_done, 0);

    f100 = 69'd354224848179261915075;
    run_msg(0, f100, 0, "f100", 1'b0, 1'b0, '0);
    s = "1333DB76A7C594BFC3";
    base = rx_n[0] - 20;
    nb = 0;
    for (int k = 0; k < 18; k++)
      if (base + k < 0 || rx_buf[0][base+k] != s[k]) nb++;
    chk("f100_literal", nb, 0);

    run_msg(0, 69'h1F, 0, "x1f", 1'b0, 1'b0, '0);
    run_msg(0, {69{1'b1}}, 0, "allones", 1'b0, 1'b0, '0);

    run_msg(0, rnd(), 2, "hold", 1'b0, 1'b0, '0);
    run_msg(0, rnd(), 1, "reedge", 1'b0, 1'b0, '0);

    for (int r = 0; r < 3; r++) run_msg(0, rnd(), 0, $sformatf("rnd%0d", r), 1'b0, 1'b0, '0);
    ra = rnd();
    rb = rnd();
    run_msg(0, ra, 0, "chain_a", 1'b0, 1'b1, rb);
    run_msg(0, rb, 0, "chain_b", 1'b1, 1'b0, '0);

    // Abort during character 5's data bits (frame starts at cycle 200, data 204..235).
    base = rx_n[0];
    @(negedge clk);
    b1.data = rnd();
    b1.load = 1'b1;
    @(posedge clk);
    for (int i = 0; i <= 210; i++) begin
      @(negedge clk);
      if (i == 10) b1.load = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_tx", b1.tx, 1'b1);
    chk("abort_busy", b1.busy, 1'b0);
    chk("abort_done", b1.done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    bad_tx = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (b1.tx != 1'b1 || b1.busy != 1'b0) bad_tx++;
    end
    chk("abort_quiet", bad_tx, 0);
    chk("abort_bytes", rx_n[0] - base, 5);
    run_msg(0, rnd(), 0, "after_abort", 1'b0, 1'b0, '0);

    run_msg(1, 69'hA, 0, "nocrlf_a", 1'b0, 1'b0, '0);
    chk("nocrlf_last", rx_buf[1][rx_n[1] > 0 ? rx_n[1] - 1 : 0], 8'h41);
    run_msg(1, rnd(), 0, "nocrlf_rnd", 1'b0, 1'b0, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
